// File: rtl/rx_frame_pkg.sv
// Shared constants for the UART frame controller: FSM state encodings and error codes.
package rx_frame_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PAYLOAD  = 3'd1;
  localparam logic [2:0] ST_CHECKSUM = 3'd2;
  localparam logic [2:0] ST_READY    = 3'd3;
  localparam logic [2:0] ST_ERROR    = 3'd4;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_PARITY   = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/rx_frame_ctrl_if.sv
// Byte-in / frame-out bundle between the UART receiver, the frame controller and its consumer.
interface rx_frame_ctrl_if #(
  parameter int N_BITS  = 8,
  parameter int N_BYTES = 4
);
  logic                      byte_valid;
  logic [N_BITS-1:0]         byte_data;
  logic                      byte_parity_ok;
  logic                      frame_ack;
  logic                      frame_valid;
  logic [N_BYTES*N_BITS-1:0] frame_data;
  logic                      err;
  logic [1:0]                err_code;
  logic                      overrun;
  logic [2:0]                db_estado;

  modport master (
    output byte_valid, byte_data, byte_parity_ok, frame_ack,
    input  frame_valid, frame_data, err, err_code, overrun, db_estado
  );

  modport slave (
    input  byte_valid, byte_data, byte_parity_ok, frame_ack,
    output frame_valid, frame_data, err, err_code, overrun, db_estado
  );
endinterface

// File: rtl/rx_frame_timer.sv
// Clearable, enabled inter-byte idle counter; tc_o flags the last allowed idle cycle.
module rx_frame_timer #(
  parameter int TIMEOUT_CYCLES = 114_576,
  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = en_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/rx_frame_ctrl.sv
// Frame assembler behind the UART receiver: header hunt, fixed payload, XOR checksum,
// valid/ack hand-off of the completed frame plus parity/checksum/timeout/overrun reporting.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int          N_BITS         = 8,
  parameter int          N_BYTES        = 4,
  parameter logic [7:0]  HEADER         = 8'hAA,
  parameter int          TIMEOUT_CYCLES = 114_576
) (
  input  logic           clock,
  input  logic           reset,
  rx_frame_ctrl_if.slave bus
);
  localparam int IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

  logic [2:0]                         state_q, state_d;
  logic [IW-1:0]                      idx_q, idx_d;
  logic [N_BITS-1:0]                  acc_q, acc_d;
  logic [N_BYTES-1:0][N_BITS-1:0]     buf_q, buf_d;
  logic [N_BYTES-1:0][N_BITS-1:0]     frame_q, frame_d;
  logic [1:0]                         err_code_q, err_code_d;
  logic                               overrun_q, overrun_d;
  logic                               err_q, frame_valid_q;
  logic                               in_frame, tc, is_header;

  assign in_frame  = (state_q == ST_PAYLOAD) || (state_q == ST_CHECKSUM);
  assign is_header = bus.byte_parity_ok && (bus.byte_data == N_BITS'(HEADER));

  // Idle timer restarts on every byte and sits at zero outside a frame.
  rx_frame_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock (clock),
    .reset (reset),
    .clr_i (bus.byte_valid || !in_frame),
    .en_i  (in_frame),
    .tc_o  (tc)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    err_code_d = err_code_q;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.byte_valid && is_header) begin
          state_d = ST_PAYLOAD;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_PAYLOAD: begin
        if (bus.byte_valid) begin
          if (!bus.byte_parity_ok) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_PARITY;
          end else begin
            buf_d[idx_q] = bus.byte_data;
            acc_d        = acc_q ^ bus.byte_data;
            if (idx_q == IW'(N_BYTES - 1)) state_d = ST_CHECKSUM;
            else                           idx_d   = idx_q + 1'b1;
          end
        end else if (tc) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_CHECKSUM: begin
        if (bus.byte_valid) begin
          if (!bus.byte_parity_ok) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_PARITY;
          end else if (bus.byte_data == acc_q) begin
            state_d = ST_READY;
            frame_d = buf_q;
          end else begin
            state_d    = ST_ERROR;
            err_code_d = ERR_CHECKSUM;
          end
        end else if (tc) begin
          state_d    = ST_ERROR;
          err_code_d = ERR_TIMEOUT;
        end
      end
      ST_READY: begin
        // An ack frees the slot this cycle, so a coincident byte is judged as if idle.
        if (bus.frame_ack) begin
          state_d = ST_IDLE;
          if (bus.byte_valid && is_header) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
            acc_d   = '0;
          end
        end else if (bus.byte_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      buf_q         <= '0;
      frame_q       <= '0;
      err_code_q    <= ERR_NONE;
      overrun_q     <= 1'b0;
      err_q         <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      buf_q         <= buf_d;
      frame_q       <= frame_d;
      err_code_q    <= err_code_d;
      overrun_q     <= overrun_d;
      err_q         <= (state_d == ST_ERROR);
      frame_valid_q <= (state_d == ST_READY);
    end
  end

  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_data  = frame_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.overrun     = overrun_q;
  assign bus.db_estado   = state_q;
endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed-vector bench for rx_frame_ctrl with a shortened timeout of 100 cycles.
module tb_rx_frame_ctrl;
  localparam int N_BITS  = 8;
  localparam int N_BYTES = 4;
  localparam int TMO     = 100;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  rx_frame_ctrl_if #(.N_BITS(N_BITS), .N_BYTES(N_BYTES)) bus ();

  rx_frame_ctrl #(
    .N_BITS(N_BITS), .N_BYTES(N_BYTES), .HEADER(8'hAA), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic pok);
    bus.byte_valid     = 1'b1;
    bus.byte_data      = d;
    bus.byte_parity_ok = pok;
    tick();
    bus.byte_valid     = 1'b0;
    bus.byte_parity_ok = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, b3, b4);
    send(8'hAA, 1'b1);
    send(b0, 1'b1);
    send(b1, 1'b1);
    send(b2, 1'b1);
    send(b3, 1'b1);
    send(b4, 1'b1);
  endtask

  task automatic ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
  endtask

  initial begin
    bus.byte_valid     = 1'b0;
    bus.byte_data      = '0;
    bus.byte_parity_ok = 1'b1;
    bus.frame_ack      = 1'b0;
    tick();
    tick();
    chk("rst_fv",   bus.frame_valid, 1'b0);
    chk("rst_fd",   bus.frame_data,  32'h0);
    chk("rst_err",  bus.err,         1'b0);
    chk("rst_code", bus.err_code,    2'b00);
    chk("rst_ovr",  bus.overrun,     1'b0);
    chk("rst_st",   bus.db_estado,   3'd0);
    reset = 1'b0;
    tick();

    // good frame
    send(8'hAA, 1'b1);
    chk("hdr_st", bus.db_estado, 3'd1);
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
    chk("pl_st",  bus.db_estado,   3'd2);
    chk("pl_fv",  bus.frame_valid, 1'b0);
    chk("pl_fd",  bus.frame_data,  32'h0);
    send(8'h44, 1'b1);
    chk("good_fv",  bus.frame_valid, 1'b1);
    chk("good_fd",  bus.frame_data,  32'h44332211);
    chk("good_st",  bus.db_estado,   3'd3);
    chk("good_err", bus.err,         1'b0);
    ack();
    chk("ack_fv", bus.frame_valid, 1'b0);
    chk("ack_st", bus.db_estado,   3'd0);
    chk("ack_fd", bus.frame_data,  32'h44332211);

    // checksum error
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
    chk("cs_err",  bus.err,         1'b1);
    chk("cs_code", bus.err_code,    2'b10);
    chk("cs_st",   bus.db_estado,   3'd4);
    chk("cs_fv",   bus.frame_valid, 1'b0);
    tick();
    chk("cs_err2", bus.err,       1'b0);
    chk("cs_st2",  bus.db_estado, 3'd0);
    chk("cs_hold", bus.err_code,  2'b10);

    // parity error then recovery
    send(8'hAA, 1'b1);
    send(8'h11, 1'b0);
    chk("par_err",  bus.err,      1'b1);
    chk("par_code", bus.err_code, 2'b01);
    tick();
    send_frame(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
    chk("rec_fv", bus.frame_valid, 1'b1);
    chk("rec_fd", bus.frame_data,  32'h04030201);
    ack();

    // timeout: err exactly 100 cycles after last byte
    send(8'hAA, 1'b1);
    send(8'h11, 1'b1);
    repeat (TMO - 1) tick();
    chk("tmo_pre_err", bus.err,       1'b0);
    chk("tmo_pre_st",  bus.db_estado, 3'd1);
    tick();
    chk("tmo_err",  bus.err,       1'b1);
    chk("tmo_code", bus.err_code,  2'b11);
    chk("tmo_st",   bus.db_estado, 3'd4);
    tick();
    chk("tmo_idle", bus.db_estado, 3'd0);

    // byte on the expiry cycle wins
    send(8'hAA, 1'b1);
    send(8'h11, 1'b1);
    repeat (TMO - 1) tick();
    send(8'h22, 1'b1);
    chk("exp_err", bus.err,       1'b0);
    chk("exp_st",  bus.db_estado, 3'd1);
    send(8'h33, 1'b1); send(8'h44, 1'b1); send(8'h44, 1'b1);
    chk("exp_fv", bus.frame_valid, 1'b1);
    chk("exp_fd", bus.frame_data,  32'h44332211);

    // overrun while pending, then ack coincident with header
    send(8'h55, 1'b1);
    chk("ovr",    bus.overrun,     1'b1);
    chk("ovr_fv", bus.frame_valid, 1'b1);
    chk("ovr_fd", bus.frame_data,  32'h44332211);
    tick();
    chk("ovr_pulse", bus.overrun, 1'b0);
    bus.frame_ack = 1'b1;
    send(8'hAA, 1'b1);
    bus.frame_ack = 1'b0;
    chk("ackhdr_fv", bus.frame_valid, 1'b0);
    chk("ackhdr_st", bus.db_estado,   3'd1);
    chk("ackhdr_ov", bus.overrun,     1'b0);

    // reset mid-payload
    send(8'h01, 1'b1);
    reset = 1'b1;
    #1;
    chk("mrst_st",   bus.db_estado,   3'd0);
    chk("mrst_fv",   bus.frame_valid, 1'b0);
    chk("mrst_fd",   bus.frame_data,  32'h0);
    chk("mrst_err",  bus.err,         1'b0);
    chk("mrst_code", bus.err_code,    2'b00);
    tick();
    reset = 1'b0;
    tick();

    // noise in idle
    send(8'h00, 1'b1);
    chk("n00_st", bus.db_estado, 3'd0);
    send(8'hFF, 1'b1);
    chk("nff_st", bus.db_estado, 3'd0);
    send(8'hAA, 1'b0);
    chk("nbad_st",  bus.db_estado, 3'd0);
    chk("nbad_err", bus.err,       1'b0);
    tick();
    chk("n_err", bus.err, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Frame-level controller sitting directly behind the UART receiver (rx_serial). It consumes the per-byte completion pulse, data and parity flag, hunts for a header byte, and assembles a fixed-length payload followed by an XOR checksum. It presents a validated frame to the consumer with a valid/ack handshake and reports parity, checksum, timeout and overrun conditions.

## Interface
- N_BITS, 8, data bits per byte; must match the receiver.
- N_BYTES, 4, payload bytes per frame (≥1).
- HEADER, 8'hAA, start-of-frame byte value.
- TIMEOUT_CYCLES, 114_576, max idle clocks between bytes inside a frame (≈2 characters at 9600 baud / 50 MHz).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- byte_valid  in  1  one-cycle pulse per received byte (receiver `fim`).
- byte_data  in  N_BITS  received byte, valid with byte_valid.
- byte_parity_ok  in  1  receiver parity_check, valid with byte_valid.
- frame_ack  in  1  consumer accepts frame; sampled only while frame_valid=1.
- frame_valid  out  1  frame held; level until ack.
- frame_data  out  N_BYTES*N_BITS  payload; first payload byte in [N_BITS-1:0].
- err  out  1  one-cycle error pulse.
- err_code  out  2  01 parity, 10 checksum, 11 timeout; holds last code.
- overrun  out  1  one-cycle pulse: byte dropped while frame pending.
- db_estado  out  3  current state encoding, for debug.

## Operation
- States/encodings: IDLE=0, PAYLOAD=1, CHECKSUM=2, READY=3, ERROR=4.
- IDLE: on byte_valid with byte_parity_ok=1 and byte_data==HEADER → PAYLOAD, clear byte index, checksum accumulator, timer. Other bytes (incl. bad-parity header) silently ignored.
- PAYLOAD: each byte_valid stores byte at index, XORs into accumulator, index++; after byte N_BYTES-1 → CHECKSUM.
- CHECKSUM: byte_valid compares byte with accumulator; equal → READY, else → ERROR code 10.
- Any byte with byte_parity_ok=0 in PAYLOAD/CHECKSUM → ERROR code 01.
- Timer: runs only in PAYLOAD/CHECKSUM, cleared on every byte_valid; reaching TIMEOUT_CYCLES-1 without byte → ERROR code 11. byte_valid in same cycle as expiry wins (byte processed, timer cleared).
- READY: frame_valid=1, frame_data frozen. frame_ack → IDLE. byte_valid without ack → byte dropped, overrun pulse. byte_valid with ack same cycle → byte evaluated under IDLE rules (header starts new frame).
- ERROR: lasts exactly one cycle, err=1, → IDLE; byte_valid during ERROR ignored.
- frame_data is a separate register loaded on CHECKSUM→READY; internal assembly buffer never visible mid-frame; retains last good frame after ack.

## Timing
- Reset values: state IDLE, frame_valid 0, frame_data 0, err 0, err_code 00, overrun 0, db_estado 000, timer/index/accumulator 0.
- All outputs registered.
- Checksum byte_valid at cycle t → frame_valid=1 at t+1.
- Error-causing event at t → err=1 and err_code updated at t+1, IDLE at t+2.
- frame_ack at t → frame_valid=0 at t+1.
- overrun asserted cycle after the dropped byte_valid.
- Reset mid-frame: partial frame discarded, no err pulse.

## Structure
- Package rx_frame_pkg: state encoding constants, err_code constants (ERR_PARITY, ERR_CHECKSUM, ERR_TIMEOUT).
- Sub-module rx_frame_timer: clearable, enabled counter with terminal-count output, width $clog2(TIMEOUT_CYCLES).
- FSM, index, accumulator and buffers in rx_frame_ctrl; integration with the receiver done by the parent.

## Test plan
- Good frame AA 11 22 33 44 44, all parity ok → frame_valid at t+1 of last byte, frame_data=0x44332211, err never set; ack → frame_valid 0 next cycle.
- AA 11 22 33 44 45 → err pulse 1 cycle, err_code=10, frame_valid stays 0, db_estado 4 then 0.
- AA 11 (parity_ok=0) → err, err_code=01; subsequent AA 01 02 03 04 04 → frame_data=0x04030201.
- TIMEOUT_CYCLES=100: AA 11 then silence → err at exactly 100 cycles after last byte, code 11; byte arriving on expiry cycle → no error.
- Frame pending, send 55 without ack → overrun pulse, frame_data unchanged; ack coincident with AA → frame_valid 0, state PAYLOAD.
- Noise 00 FF AA(parity bad) in IDLE → stays IDLE, no err; reset asserted mid-PAYLOAD → all outputs to reset values immediately.
